// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit fronting an internal word RAM and a
// memory-mapped device window. One request at a time; RAM accesses answer one
// cycle after acceptance, device accesses wait for ack/err or a timeout.
//
// Ports:
//   clk, reset (async, active-low)
//   req_*      : request handshake (valid/ready), write, width, signed, addr, wdata
//   resp_*     : one-cycle response pulse with load data and exception code
//   dev_*      : device bus (req/we/addr/wdata out, ack/err/rdata in)
module mem_access_unit #(
   parameter int unsigned RAM_WORDS = 3072,
   parameter logic [31:0] DEV_BASE  = 32'h7F00,
   parameter logic [31:0] DEV_SIZE  = 32'h20,
   parameter int unsigned TIMEOUT   = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_width,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic [1:0]  resp_exc_code,
   output logic        dev_req,
   output logic        dev_we,
   output logic [31:0] dev_addr,
   output logic [31:0] dev_wdata,
   input  logic        dev_ack,
   input  logic        dev_err,
   input  logic [31:0] dev_rdata
);

   localparam int unsigned AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam logic [32:0] RAM_LIMIT = 33'(RAM_WORDS) << 2;
   localparam logic [32:0] DEV_END   = {1'b0, DEV_BASE} + {1'b0, DEV_SIZE};
   localparam logic [7:0]  TO_LAST   = 8'(TIMEOUT - 1);

   localparam logic [1:0] EXC_OK    = 2'd0;
   localparam logic [1:0] EXC_ALIGN = 2'd1;
   localparam logic [1:0] EXC_FAULT = 2'd2;
   localparam logic [1:0] EXC_DEV   = 2'd3;

   typedef enum logic [1:0] {IDLE, RESP, DEV_WAIT} state_t;

   state_t      state_q, state_d;
   logic        ready_q, ready_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic [1:0]  resp_exc_q, resp_exc_d;
   logic        dev_req_q, dev_req_d;
   logic        dev_we_q, dev_we_d;
   logic [31:0] dev_addr_q, dev_addr_d;
   logic [31:0] dev_wdata_q, dev_wdata_d;
   logic [7:0]  cnt_q, cnt_d;

   logic [31:0] mem [RAM_WORDS];

   logic          accept_c, misaligned_c, in_ram_c, in_dev_c, fault_c, ram_we_c;
   logic [AW-1:0] idx_c;
   logic [3:0]    be_c;
   logic [31:0]   wlane_c, ram_word_c, load_c;
   logic [7:0]    byte_c;
   logic [15:0]   half_c;

   // Request decode: alignment, window hits, RAM index
   assign accept_c     = req_valid && ready_q;
   assign misaligned_c = (req_width == 2'd1 && req_addr[0]) ||
                         (req_width == 2'd2 && req_addr[1:0] != 2'b00);
   assign in_ram_c     = {1'b0, req_addr} < RAM_LIMIT;
   assign in_dev_c     = (req_addr >= DEV_BASE) && ({1'b0, req_addr} < DEV_END);
   assign fault_c      = (req_width == 2'd3) || !(in_ram_c || in_dev_c) ||
                         (in_dev_c && req_width != 2'd2);
   assign idx_c        = req_addr[AW+1:2];

   // Store lane enables and replicated write data
   always_comb begin
      be_c    = 4'b1111;
      wlane_c = req_wdata;
      case (req_width)
         2'd0: begin
            be_c    = 4'b0001 << req_addr[1:0];
            wlane_c = {4{req_wdata[7:0]}};
         end
         2'd1: begin
            be_c    = req_addr[1] ? 4'b1100 : 4'b0011;
            wlane_c = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Load lane select and extension
   assign ram_word_c = mem[idx_c];
   assign byte_c     = ram_word_c[{req_addr[1:0], 3'b000} +: 8];
   assign half_c     = ram_word_c[{req_addr[1], 4'b0000} +: 16];

   always_comb begin
      load_c = ram_word_c;
      case (req_width)
         2'd0:    load_c = req_signed ? {{24{byte_c[7]}}, byte_c} : {24'h0, byte_c};
         2'd1:    load_c = req_signed ? {{16{half_c[15]}}, half_c} : {16'h0, half_c};
         default: ;
      endcase
   end

   // Next-state and output logic
   always_comb begin
      state_d      = state_q;
      resp_rdata_d = resp_rdata_q;
      resp_exc_d   = resp_exc_q;
      dev_we_d     = dev_we_q;
      dev_addr_d   = dev_addr_q;
      dev_wdata_d  = dev_wdata_q;
      cnt_d        = cnt_q;
      ram_we_c     = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept_c) begin
               if (misaligned_c || fault_c) begin
                  state_d      = RESP;
                  resp_rdata_d = 32'h0;
                  resp_exc_d   = misaligned_c ? EXC_ALIGN : EXC_FAULT;
               end else if (in_dev_c) begin
                  state_d     = DEV_WAIT;
                  dev_we_d    = req_write;
                  dev_addr_d  = req_addr;
                  dev_wdata_d = req_wdata;
                  cnt_d       = 8'h0;
               end else begin
                  state_d      = RESP;
                  ram_we_c     = req_write && reset;
                  resp_rdata_d = req_write ? 32'h0 : load_c;
                  resp_exc_d   = EXC_OK;
               end
            end
         end
         RESP: state_d = IDLE;
         DEV_WAIT: begin
            // err beats ack; timeout fires after TIMEOUT dev_req cycles
            if (dev_err || dev_ack || cnt_q == TO_LAST) begin
               state_d      = RESP;
               dev_we_d     = 1'b0;
               cnt_d        = 8'h0;
               resp_exc_d   = (dev_ack && !dev_err) ? EXC_OK : EXC_DEV;
               resp_rdata_d = (dev_ack && !dev_err && !dev_we_q) ? dev_rdata : 32'h0;
            end else begin
               cnt_d = cnt_q + 8'h1;
            end
         end
         default: state_d = IDLE;
      endcase
      ready_d      = (state_d == IDLE);
      resp_valid_d = (state_d == RESP);
      dev_req_d    = (state_d == DEV_WAIT);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         ready_q      <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'h0;
         resp_exc_q   <= 2'd0;
         dev_req_q    <= 1'b0;
         dev_we_q     <= 1'b0;
         dev_addr_q   <= 32'h0;
         dev_wdata_q  <= 32'h0;
         cnt_q        <= 8'h0;
      end else begin
         state_q      <= state_d;
         ready_q      <= ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_exc_q   <= resp_exc_d;
         dev_req_q    <= dev_req_d;
         dev_we_q     <= dev_we_d;
         dev_addr_q   <= dev_addr_d;
         dev_wdata_q  <= dev_wdata_d;
         cnt_q        <= cnt_d;
      end
   end

   // RAM byte-lane write; contents survive reset
   always_ff @(posedge clk) begin
      if (ram_we_c) begin
         for (int b = 0; b < 4; b++) begin
            if (be_c[b]) mem[idx_c][8*b +: 8] <= wlane_c[8*b +: 8];
         end
      end
   end

   assign req_ready     = ready_q;
   assign resp_valid    = resp_valid_q;
   assign resp_rdata    = resp_rdata_q;
   assign resp_exc_code = resp_exc_q;
   assign dev_req       = dev_req_q;
   assign dev_we        = dev_we_q;
   assign dev_addr      = dev_addr_q;
   assign dev_wdata     = dev_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random
// accesses compared against a byte-addressed memory model.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write, req_signed;
   logic [1:0]  req_width;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_exc_code;
   logic        dev_req, dev_we, dev_ack, dev_err;
   logic [31:0] dev_addr, dev_wdata, dev_rdata;

   int checks = 0;
   int errors = 0;

   logic [7:0] ram_model [256];

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_width(req_width), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_exc_code(resp_exc_code), .dev_req(dev_req), .dev_we(dev_we),
      .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_ack(dev_ack),
      .dev_err(dev_err), .dev_rdata(dev_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit is_dev(input logic [31:0] a);
      return (a >= 32'h7F00) && (a < 32'h7F20);
   endfunction

   // 0 means "proceeds to RAM or device"
   function automatic logic [1:0] pre_code(input logic [1:0] w, input logic [31:0] a);
      if ((w == 2'd1 && a[0]) || (w == 2'd2 && a[1:0] != 2'b00)) return 2'd1;
      if (w == 2'd3) return 2'd2;
      if (is_dev(a)) return (w == 2'd2) ? 2'd0 : 2'd2;
      if (a < 32'd12288) return 2'd0;
      return 2'd2;
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] w, input bit sg,
                                              input logic [31:0] a);
      int n = 1 << w;
      logic [31:0] v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(ram_model[int'(a) + i]) << (8 * i));
      if (sg && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
      return v;
   endfunction

   task automatic access(input bit wr, input logic [1:0] w, input bit sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int ack_at, input bit with_ack, input bit with_err,
                         input logic [31:0] drd, input string tag,
                         output logic [31:0] got_data);
      logic [1:0]  exp_code;
      logic [31:0] exp_data;
      bit          go_dev, got;
      int          exp_dcnt, g, it, dcnt;
      logic [1:0]  got_code;
      got_data = 32'h0;
      got_code = 2'd0;
      exp_code = pre_code(w, a);
      go_dev   = (exp_code == 2'd0) && is_dev(a);
      exp_dcnt = (with_ack || with_err) ? ack_at : 15;
      exp_data = 32'h0;
      if (go_dev) begin
         exp_code = with_err ? 2'd3 : (with_ack ? 2'd0 : 2'd3);
         if (!wr && with_ack && !with_err) exp_data = drd;
      end else if (exp_code == 2'd0 && !wr) begin
         exp_data = model_load(w, sg, a);
      end
      g = 0;
      while (req_ready !== 1'b1 && g < 20) begin @(negedge clk); g++; end
      chk({tag, "_ready"}, 32'(req_ready), 32'h1);
      req_valid = 1'b1; req_write = wr; req_width = w; req_signed = sg;
      req_addr = a; req_wdata = wd; dev_rdata = drd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      it = 0; dcnt = 0; got = 1'b0;
      while (!got && it < 60) begin
         @(negedge clk);
         it++;
         if (resp_valid === 1'b1) begin
            got = 1'b1;
            got_data = resp_rdata;
            got_code = resp_exc_code;
            chk({tag, "_devreq_in_resp"}, 32'(dev_req), 32'h0);
            dev_ack = 1'b0; dev_err = 1'b0;
         end else if (dev_req === 1'b1) begin
            dcnt++;
            if (!go_dev) chk({tag, "_spurious_dev_req"}, 32'(dev_req), 32'h0);
            else begin
               chk({tag, "_dev_addr"}, dev_addr, a);
               chk({tag, "_dev_we"}, 32'(dev_we), 32'(wr));
               if (wr) chk({tag, "_dev_wdata"}, dev_wdata, wd);
            end
            dev_ack = with_ack && (dcnt == ack_at);
            dev_err = with_err && (dcnt == ack_at);
         end else begin
            dev_ack = 1'b0; dev_err = 1'b0;
         end
      end
      chk({tag, "_resp_seen"}, 32'(got), 32'h1);
      if (got) begin
         chk({tag, "_code"}, 32'(got_code), 32'(exp_code));
         chk({tag, "_rdata"}, got_data, exp_data);
         if (go_dev) chk({tag, "_dev_cycles"}, 32'(dcnt), 32'(exp_dcnt));
         else        chk({tag, "_latency"}, 32'(it), 32'h1);
      end
      @(negedge clk);
      chk({tag, "_pulse_end"}, 32'(resp_valid), 32'h0);
      chk({tag, "_ready_after"}, 32'(req_ready), 32'h1);
      if (!go_dev && exp_code == 2'd0 && wr)
         for (int i = 0; i < (1 << w); i++) ram_model[int'(a) + i] = wd[8*i +: 8];
   endtask

   initial begin
      logic [31:0] d;
      bit          seen;
      reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_width = 2'd0;
      req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      dev_ack = 1'b0; dev_err = 1'b0; dev_rdata = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst_resp_valid", 32'(resp_valid), 32'h0);
      chk("rst_rdata", resp_rdata, 32'h0);
      chk("rst_code", 32'(resp_exc_code), 32'h0);
      chk("rst_dev_req", 32'(dev_req), 32'h0);
      chk("rst_dev_we", 32'(dev_we), 32'h0);
      reset = 1'b1;
      @(negedge clk);
      chk("first_ready", 32'(req_ready), 32'h1);

      for (int i = 0; i < 64; i++)
         access(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, 1, 1'b0, 1'b0, 32'h0, "fill", d);

      access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1, 1'b0, 1'b0, 32'h0, "st_w", d);
      access(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1, 1'b0, 1'b0, 32'h0, "ld_bs", d);
      chk("ld_bs_const", d, 32'hFFFFFFDE);
      access(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 1, 1'b0, 1'b0, 32'h0, "ld_hu", d);
      chk("ld_hu_const", d, 32'h0000BEEF);
      access(1'b1, 2'd0, 1'b0, 32'h11, 32'h5A, 1, 1'b0, 1'b0, 32'h0, "st_b", d);
      access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1, 1'b0, 1'b0, 32'h0, "ld_w", d);
      chk("ld_w_const", d, 32'hDEAD5AEF);

      access(1'b0, 2'd2, 1'b0, 32'h2, 32'h0, 1, 1'b0, 1'b0, 32'h0, "mis_w", d);
      access(1'b0, 2'd1, 1'b0, 32'h5, 32'h0, 1, 1'b0, 1'b0, 32'h0, "mis_h", d);
      access(1'b0, 2'd2, 1'b0, 32'h3000, 32'h0, 1, 1'b0, 1'b0, 32'h0, "oob_w", d);
      access(1'b0, 2'd0, 1'b0, 32'h7F00, 32'h0, 1, 1'b0, 1'b0, 32'h0, "dev_b", d);
      access(1'b1, 2'd2, 1'b0, 32'h12, 32'h11111111, 1, 1'b0, 1'b0, 32'h0, "mis_st", d);
      access(1'b1, 2'd3, 1'b0, 32'h10, 32'h22222222, 1, 1'b0, 1'b0, 32'h0, "w3_st", d);
      access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1, 1'b0, 1'b0, 32'h0, "ld_w2", d);
      chk("no_ram_change", d, 32'hDEAD5AEF);

      access(1'b0, 2'd2, 1'b0, 32'h7F04, 32'h0, 3, 1'b1, 1'b0, 32'h12345678, "dev_ack", d);
      chk("dev_ack_const", d, 32'h12345678);
      access(1'b0, 2'd2, 1'b0, 32'h7F04, 32'h0, 2, 1'b1, 1'b1, 32'hCAFEF00D, "dev_err", d);
      access(1'b1, 2'd2, 1'b0, 32'h7F1C, 32'hA5A5A5A5, 1, 1'b1, 1'b0, 32'h0, "dev_st", d);
      access(1'b0, 2'd2, 1'b0, 32'h7F08, 32'h0, 1, 1'b0, 1'b0, 32'h0, "dev_to", d);

      // reset in the middle of a device store
      req_valid = 1'b1; req_write = 1'b1; req_width = 2'd2; req_signed = 1'b0;
      req_addr = 32'h7F0C; req_wdata = 32'h55AA55AA;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("midrst_devreq_before", 32'(dev_req), 32'h1);
      #2 reset = 1'b0;
      #1;
      chk("midrst_devreq", 32'(dev_req), 32'h0);
      chk("midrst_devwe", 32'(dev_we), 32'h0);
      chk("midrst_resp_valid", 32'(resp_valid), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (resp_valid === 1'b1 || dev_req === 1'b1) seen = 1'b1;
      end
      chk("midrst_quiet", 32'(seen), 32'h0);
      chk("midrst_ready", 32'(req_ready), 32'h1);

      for (int n = 0; n < 200; n++) begin
         int          r;
         logic [31:0] a;
         r = $urandom_range(0, 9);
         if (r == 0)      a = 32'h7F00 + 32'($urandom_range(0, 31));
         else if (r == 1) a = 32'h3000 + 32'($urandom_range(0, 4095));
         else             a = 32'($urandom_range(0, 252)) + 32'($urandom_range(0, 3));
         access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), a, $urandom,
                $urandom_range(1, 4), 1'b1, ($urandom_range(0, 3) == 0),
                $urandom, "rnd", d);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
